// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared state encoding and image-format constants for the ROM loader
package uart_prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR_HI = 3'd1,
      ST_DATA   = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERROR  = 3'd4
   } loader_state_e;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_prog_loader_timeout.sv
// rtl/uart_prog_loader_timeout.sv - idle-cycle counter that pulses expire_o when the byte gap gets too long
module upg_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at LIMIT so expire stays asserted until the owner leaves the active states.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - turns a UART byte stream (16-bit count + LE words) into program ROM word writes
module uart_prog_loader
   import uart_prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W         = 14,
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
   input  logic              upg_clk_i,
   input  logic              upg_rst_i,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   output logic              upg_wen_o,
   output logic [ADDR_W-1:0] upg_adr_o,
   output logic [31:0]       upg_dat_o,
   output logic              upg_done_o,
   output logic              upg_err_o,
   output logic              busy_o
);

   localparam int unsigned CMP_W = (ADDR_W + 1 > 16) ? ADDR_W + 1 : 16;
   localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << ADDR_W;
   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   loader_state_e     state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [23:0]       asm_q, asm_d;
   logic [ADDR_W:0]   widx_q, widx_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [31:0]       dat_q, dat_d;

   logic [15:0]       hdr_n;
   logic              all_written;
   logic              tmo_en;
   logic              tmo_expire;

   assign tmo_en = (state_q == ST_HDR_HI) || (state_q == ST_DATA);

   upg_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (upg_clk_i),
      .rst_i    (upg_rst_i),
      .clr_i    (rx_valid_i),
      .en_i     (tmo_en),
      .expire_o (tmo_expire)
   );

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      byte_cnt_d  = byte_cnt_q;
      asm_d       = asm_q;
      widx_d      = widx_q;
      wen_d       = 1'b0;
      adr_d       = adr_q;
      dat_d       = dat_q;
      hdr_n       = {rx_data_i, n_q[7:0]};
      all_written = (CMP_W'(widx_q) == CMP_W'(n_q));

      case (state_q)
         ST_IDLE: begin
            if (rx_valid_i) begin
               n_d     = {8'h00, rx_data_i};
               state_d = ST_HDR_HI;
            end
         end
         ST_HDR_HI: begin
            if (tmo_expire) begin
               state_d = ST_ERROR;
            end else if (rx_valid_i) begin
               n_d = hdr_n;
               if (hdr_n == 16'd0) begin
                  state_d = ST_DONE;
               end else if (CMP_W'(hdr_n) > MAX_WORDS) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            // widx only advances alongside a write, so all_written first holds in the last wen cycle.
            if (all_written) begin
               state_d = ST_DONE;
            end else if (tmo_expire) begin
               state_d = ST_ERROR;
            end else if (rx_valid_i) begin
               if (byte_cnt_q == LAST_BYTE) begin
                  wen_d      = 1'b1;
                  adr_d      = widx_q[ADDR_W-1:0];
                  dat_d      = {rx_data_i, asm_q};
                  widx_d     = widx_q + (ADDR_W + 1)'(1);
                  byte_cnt_d = 2'd0;
               end else begin
                  case (byte_cnt_q)
                     2'd0:    asm_d[7:0]   = rx_data_i;
                     2'd1:    asm_d[15:8]  = rx_data_i;
                     default: asm_d[23:16] = rx_data_i;
                  endcase
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge upg_clk_i) begin
      if (upg_rst_i) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         widx_q     <= '0;
         wen_q      <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         widx_q     <= widx_d;
         wen_q      <= wen_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
      end
   end

   assign upg_wen_o  = wen_q;
   assign upg_adr_o  = adr_q;
   assign upg_dat_o  = dat_q;
   assign upg_done_o = (state_q == ST_DONE);
   assign upg_err_o  = (state_q == ST_ERROR);
   assign busy_o     = tmo_en;

endmodule
